clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Synchronous 4-channel clock-divider controller that replaces ripple-toggle division with clock-enable ticks derived from one clk domain. Each channel has a programmable divisor, a tick output and a 50%-duty divided output. A small FSM sequences start, a glitch-free drained stop, and safe on-the-fly divisor reconfiguration through a single-entry config port with acknowledge. It sits between the board clock and the downstream blocks that need slow enables, such as display scanning, debouncing and LED blinking.

Parameters:
WIDTH, 8, bit width of each divisor and channel counter; maximum divisor is 2^WIDTH-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  level-sampled request to begin dividing
stop  input  1  level-sampled request to stop (drained)
cfg_we  input  1  config write strobe, one-cycle
cfg_sel  input  2  target channel of config write
cfg_div  input  WIDTH  new divisor; 0 = channel disabled
cfg_busy  output  1  a config write is pending; new cfg_we is ignored
cfg_ack  output  1  one-cycle pulse on the edge a pending write takes effect
tick  output  4  per-channel one-cycle clock enable
div_out  output  4  per-channel toggling divided clock (registered)
running  output  1  high in RUN and DRAIN
state  output  2  IDLE=0, RUN=1, DRAIN=2

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; cnt[i]=0; div_out=0; cfg_busy=0; cfg_ack=0; pending cleared. Divisors reset to D0=1, D1=2, D2=4, D3=8, giving the clk/2, /4, /8, /16 cascade on div_out.
- Ticks: tick[i] is combinational and equals (state!=IDLE) && (D[i]!=0) && (cnt[i]==D[i]-1) && !frozen[i]. tick is 0 in IDLE.
- Counting: when tick[i] is high, cnt[i] returns to 0 and div_out[i] toggles. Otherwise, while active, cnt[i] increments.
- Period: div_out[i] period is 2*D[i] clk cycles.
- IDLE:
  - cnt and frozen are held at 0.
  - start=1 moves to RUN on the next edge. The first tick of a channel with D=1 occurs in the first RUN cycle.
  - stop is ignored.
- RUN:
  - stop=1 moves to DRAIN next edge. stop wins over a simultaneous start.
  - start is ignored.
- DRAIN:
  - On entry, any channel with div_out[i]=0 or D[i]=0 is frozen, with cnt held at 0.
  - Other channels keep counting until their next tick. That tick drives div_out[i] to 0, and the channel freezes on that edge.
  - When all 4 channels are frozen, the FSM goes to IDLE on the next edge.
  - start=1 in DRAIN returns to RUN next edge. Frozen channels unfreeze with cnt=0; the others keep their count.
- Config writes:
  - cfg_we is accepted only when cfg_busy=0.
  - In IDLE, D[cfg_sel] is updated on the next edge, cfg_ack pulses in that cycle, and cfg_busy stays 0.
  - In RUN or DRAIN, the value is latched as pending and cfg_busy=1 from the next cycle.
  - The pending value is applied on the edge where the target channel ticks, is frozen, or has D=0. At that edge, cnt is cleared to 0, cfg_ack=1 for one cycle, and cfg_busy falls.
  - A write in the same cycle as an FSM transition is evaluated against the current state.
- Disable: writing D=0 clears div_out[i] to 0 on the apply edge, and the channel produces no ticks.
- Arithmetic: cnt[i] is WIDTH bits and compares against D[i]-1 with no overflow path.
- Reset mid-operation: asserting reset forces all outputs to their reset values immediately, without waiting for clk.

Test Plan:
- Defaults: reset, then start=1 for one cycle -> tick[0] every cycle; div_out[0..3] periods 2/4/8/16 cycles; running=1, state=1.
- Reconfig in RUN: cfg_we, cfg_sel=2, cfg_div=3 mid-period -> cfg_busy=1 until ch2's next tick; cfg_ack on that edge; div_out[2] period then 6 cycles. A second cfg_we while busy leaves D unchanged.
- Drained stop: stop with div_out=4'b1010 -> state=2. ch1 toggles low at its tick, then ch3 at its tick; IDLE follows one edge later; div_out=0 with no partial-high pulses.
- Disable: in RUN, write ch0 div=0 -> div_out[0]=0 and tick[0]=0 from the ack cycle; other channels unaffected.
- Reset mid-run: assert reset asynchronously between edges -> div_out=0, tick=0, state=0 immediately; divisors revert to 1/2/4/8.
- Simultaneous events: start and stop together in IDLE -> RUN; in RUN -> DRAIN; start during DRAIN -> back to RUN with no lost count on unfrozen channels.

Source files
------------

// File: rtl/clkdiv_if.sv
// Control, configuration and status bundle for clkdiv_ctrl.
// master drives the requests and config writes; slave is the divider controller.
interface clkdiv_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_busy;
    logic             cfg_ack;
    logic [3:0]       tick;
    logic [3:0]       div_out;
    logic             running;
    logic [1:0]       state;

    modport master (
        output start, stop, cfg_we, cfg_sel, cfg_div,
        input  cfg_busy, cfg_ack, tick, div_out, running, state
    );

    modport slave (
        input  start, stop, cfg_we, cfg_sel, cfg_div,
        output cfg_busy, cfg_ack, tick, div_out, running, state
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Four-channel clock-enable divider with drained stop and tick-aligned divisor updates.
// All channels count in the clk domain; div_out is a registered 50%-duty toggle.
module clkdiv_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    clkdiv_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             pend_valid_reg;
    logic [1:0]       pend_sel_reg;
    logic [WIDTH-1:0] pend_div_reg;
    logic             cfg_ack_reg;

    logic             active;
    logic             accept;
    logic             drain_next;
    logic [WIDTH-1:0] upd_val;
    logic [3:0]       tick_c;
    logic [3:0]       upd_c;
    logic [3:0]       freeze_c;
    logic [3:0]       frozen_w;
    logic [3:0]       div_out_w;

    assign active     = (state_reg != IDLE);
    assign accept     = bus.cfg_we && !pend_valid_reg;
    assign drain_next = (state_next == DRAIN);
    // A direct IDLE write and a pending apply can never coincide (accept needs !busy).
    assign upd_val    = pend_valid_reg ? pend_div_reg : bus.cfg_div;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (bus.stop)  state_next = DRAIN;
            DRAIN: begin
                if (bus.start)      state_next = RUN;
                else if (&frozen_w) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            pend_valid_reg <= 1'b0;
            pend_sel_reg   <= 2'd0;
            pend_div_reg   <= '0;
            cfg_ack_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_ack_reg <= |upd_c;
            if (accept && active) begin
                pend_valid_reg <= 1'b1;
                pend_sel_reg   <= bus.cfg_sel;
                pend_div_reg   <= bus.cfg_div;
            end else if (|upd_c) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH-1:0] div_reg;
            logic             div_out_reg;
            logic             frozen_reg;

            assign tick_c[gi] = active && (div_reg != '0) && !frozen_reg &&
                                (cnt_reg == div_reg - WIDTH'(1));

            // A channel is safe to retarget when it is at a period boundary or not counting.
            assign upd_c[gi] = (accept && (state_reg == IDLE) && (bus.cfg_sel == 2'(gi))) ||
                               (pend_valid_reg && (pend_sel_reg == 2'(gi)) &&
                                (!active || tick_c[gi] || frozen_reg || (div_reg == '0)));

            // While draining, a channel parks as soon as its output is (or is about to be) low.
            assign freeze_c[gi] = drain_next && !frozen_reg &&
                                  (!div_out_reg || (div_reg == '0) || tick_c[gi] ||
                                   (upd_c[gi] && (upd_val == '0)));

            assign frozen_w[gi]  = frozen_reg;
            assign div_out_w[gi] = div_out_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg     <= '0;
                    div_reg     <= WIDTH'(1 << gi);
                    div_out_reg <= 1'b0;
                    frozen_reg  <= 1'b0;
                end else begin
                    if (upd_c[gi]) begin
                        div_reg <= upd_val;
                    end
                    if (freeze_c[gi]) begin
                        frozen_reg  <= 1'b1;
                        cnt_reg     <= '0;
                        div_out_reg <= 1'b0;
                    end else begin
                        frozen_reg <= frozen_reg && drain_next;
                        if (!active || frozen_reg || tick_c[gi] || upd_c[gi] || (div_reg == '0)) begin
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + WIDTH'(1);
                        end
                        if (upd_c[gi] && (upd_val == '0)) begin
                            div_out_reg <= 1'b0;
                        end else if (tick_c[gi]) begin
                            div_out_reg <= ~div_out_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign bus.tick     = tick_c;
    assign bus.div_out  = div_out_w;
    assign bus.cfg_busy = pend_valid_reg;
    assign bus.cfg_ack  = cfg_ack_reg;
    assign bus.running  = active;
    assign bus.state    = state_reg;
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: defaults, reconfig, disable, async reset, drained stop, restart.
module tb_clkdiv_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    clkdiv_if #(.WIDTH(WIDTH)) bus();

    clkdiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {tick, div_out} expected k cycles after RUN entry; mode 1 = ch2 retimed to /3 at k=36,
    // mode 2 = additionally ch0 disabled.
    function automatic logic [7:0] exp_vec(input int kk, input int mode);
        logic [3:0] t;
        logic [3:0] d;
        int dv;
        for (int i = 0; i < 4; i++) begin
            dv   = 1 << i;
            t[i] = ((kk % dv) == dv - 1);
            d[i] = (((kk / dv) % 2) == 1);
        end
        if (mode >= 1) begin
            t[2] = (((kk - 36) % 3) == 2);
            d[2] = ((((kk - 36) / 3) % 2) == 0);
        end
        if (mode >= 2) begin
            t[0] = 1'b0;
            d[0] = 1'b0;
        end
        return {t, d};
    endfunction

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_div = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.state, bus.running, bus.cfg_busy, bus.cfg_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_status got=%b exp=%b", {bus.state, bus.running, bus.cfg_busy, bus.cfg_ack}, 5'b0);
        end
        checks++;
        if ({bus.tick, bus.div_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {bus.tick, bus.div_out}, 8'h00);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("FAIL idle_hold got=%0d exp=0", bus.state);
        end
    endtask

    task automatic test_defaults();
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        k = 0;
        checks++;
        if ({bus.state, bus.running} !== 3'b011) begin
            errors++;
            $display("FAIL run_entry got=%b exp=%b", {bus.state, bus.running}, 3'b011);
        end
        while (k < 33) begin
            checks++;
            if ({bus.tick, bus.div_out} !== exp_vec(k, 0)) begin
                errors++;
                $display("FAIL defaults k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 0));
            end
            step();
        end
    endtask

    task automatic test_reconfig();
        // k=33: ch2 is mid-period (cnt=1)
        bus.cfg_we = 1; bus.cfg_sel = 2; bus.cfg_div = 8'd3;
        step();
        checks++;
        if ({bus.cfg_busy, bus.cfg_ack} !== 2'b10) begin
            errors++;
            $display("FAIL reconf_busy k=%0d got=%b exp=%b", k, {bus.cfg_busy, bus.cfg_ack}, 2'b10);
        end
        bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_div = 8'd5;
        step();
        bus.cfg_we = 0;
        checks++;
        if ({bus.cfg_busy, bus.cfg_ack, bus.tick[2]} !== 3'b101) begin
            errors++;
            $display("FAIL reconf_wait k=%0d got=%b exp=%b", k, {bus.cfg_busy, bus.cfg_ack, bus.tick[2]}, 3'b101);
        end
        checks++;
        if ({bus.tick, bus.div_out} !== exp_vec(k, 0)) begin
            errors++;
            $display("FAIL reconf_pre k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 0));
        end
        step();
        checks++;
        if ({bus.cfg_busy, bus.cfg_ack} !== 2'b01) begin
            errors++;
            $display("FAIL reconf_ack k=%0d got=%b exp=%b", k, {bus.cfg_busy, bus.cfg_ack}, 2'b01);
        end
        checks++;
        if ({bus.tick, bus.div_out} !== exp_vec(k, 1)) begin
            errors++;
            $display("FAIL reconf_apply k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 1));
        end
        while (k < 48) begin
            step();
            checks++;
            if ({bus.cfg_ack, bus.tick, bus.div_out} !== {1'b0, exp_vec(k, 1)}) begin
                errors++;
                $display("FAIL reconf_run k=%0d got=%b exp=%b", k, {bus.cfg_ack, bus.tick, bus.div_out}, {1'b0, exp_vec(k, 1)});
            end
        end
    endtask

    task automatic test_disable();
        bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_div = 8'd0;
        step();
        bus.cfg_we = 0;
        checks++;
        if ({bus.cfg_busy, bus.tick, bus.div_out} !== {1'b1, exp_vec(k, 1)}) begin
            errors++;
            $display("FAIL dis_pend k=%0d got=%b exp=%b", k, {bus.cfg_busy, bus.tick, bus.div_out}, {1'b1, exp_vec(k, 1)});
        end
        step();
        checks++;
        if ({bus.cfg_busy, bus.cfg_ack} !== 2'b01) begin
            errors++;
            $display("FAIL dis_ack k=%0d got=%b exp=%b", k, {bus.cfg_busy, bus.cfg_ack}, 2'b01);
        end
        checks++;
        if ({bus.tick, bus.div_out} !== exp_vec(k, 2)) begin
            errors++;
            $display("FAIL dis_apply k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 2));
        end
        while (k < 56) begin
            step();
            checks++;
            if ({bus.tick, bus.div_out} !== exp_vec(k, 2)) begin
                errors++;
                $display("FAIL dis_run k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.running, bus.cfg_busy, bus.cfg_ack, bus.tick, bus.div_out} !== 13'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b",
                     {bus.state, bus.running, bus.cfg_busy, bus.cfg_ack, bus.tick, bus.div_out}, 13'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drain();
        logic [1:0] st_e [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        logic [3:0] tk_e [7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] dv_e [7] = '{4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        bus.stop = 1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("FAIL stop_in_idle got=%0d exp=0", bus.state);
        end
        bus.start = 1;
        @(negedge clk);
        bus.start = 0; bus.stop = 0;
        k = 0;
        checks++;
        if (bus.state !== 2'd1) begin
            errors++;
            $display("FAIL start_stop_idle got=%0d exp=1", bus.state);
        end
        while (k < 10) begin
            checks++;
            if ({bus.tick, bus.div_out} !== exp_vec(k, 0)) begin
                errors++;
                $display("FAIL post_reset_divs k=%0d got=%b exp=%b", k, {bus.tick, bus.div_out}, exp_vec(k, 0));
            end
            step();
        end
        checks++;
        if (bus.div_out !== 4'b1010) begin
            errors++;
            $display("FAIL drain_pre got=%b exp=1010", bus.div_out);
        end
        bus.start = 1; bus.stop = 1;
        step();
        bus.start = 0; bus.stop = 0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({bus.state, bus.tick, bus.div_out} !== {st_e[i], tk_e[i], dv_e[i]}) begin
                errors++;
                $display("FAIL drain k=%0d got=%b exp=%b", k, {bus.state, bus.tick, bus.div_out}, {st_e[i], tk_e[i], dv_e[i]});
            end
            step();
        end
    endtask

    task automatic test_drain_restart();
        logic [3:0] tk_e [4] = '{4'b0001, 4'b0011, 4'b1001, 4'b0111};
        logic [3:0] dv_e [4] = '{4'b1000, 4'b1001, 4'b1010, 4'b0011};
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        k = 0;
        while (k < 10) step();
        bus.stop = 1;
        step();
        bus.stop = 0;
        step();
        checks++;
        if ({bus.state, bus.div_out} !== {2'd2, 4'b1000}) begin
            errors++;
            $display("FAIL restart_drain k=%0d got=%b exp=%b", k, {bus.state, bus.div_out}, {2'd2, 4'b1000});
        end
        bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.state, bus.tick, bus.div_out} !== {2'd1, tk_e[i], dv_e[i]}) begin
                errors++;
                $display("FAIL restart k=%0d got=%b exp=%b", k, {bus.state, bus.tick, bus.div_out}, {2'd1, tk_e[i], dv_e[i]});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reconfig();
        test_disable();
        test_reset_mid();
        test_drain();
        test_drain_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
